// File: rtl/systolic_seq_if.sv
// Handshake/data bundle between host + operand buffers and the systolic sequencer.
// Ports: command (start/k_len/abort), result handshake, operand read port, array drive.
// master = host/buffer side, slave = sequencer side.
interface systolic_seq_if #(
  parameter int N    = 32,
  parameter int M    = 8,
  parameter int KMAX = 256
);
  localparam int KW = $clog2(KMAX + 1);
  localparam int AW = $clog2(KMAX);

  logic                   start;
  logic [KW-1:0]          k_len;
  logic                   abort;
  logic                   busy;
  logic                   res_valid;
  logic                   res_ready;
  logic                   rd_en;
  logic [AW-1:0]          rd_addr;
  logic [M-1:0][N-1:0]    rd_a;
  logic [M-1:0][N-1:0]    rd_b;
  logic                   arr_clr;
  logic                   arr_en;
  logic [M-1:0][N-1:0]    arr_x;
  logic [M-1:0][N-1:0]    arr_y;

  modport master (
    output start, k_len, abort, res_ready, rd_a, rd_b,
    input  busy, res_valid, rd_en, rd_addr, arr_clr, arr_en, arr_x, arr_y
  );

  modport slave (
    input  start, k_len, abort, res_ready, rd_a, rd_b,
    output busy, res_valid, rd_en, rd_addr, arr_clr, arr_en, arr_x, arr_y
  );
endinterface

// File: rtl/systolic_seq_ctrl.sv
// Sequencer for one MxM output-stationary systolic matmul pass (clear, feed K, drain 2M-1, hold result).
// Latency: start@t -> clear t+1, reads t+2..t+K+1, res_valid from t+K+2M+1 (t+2 when K=0).
// Backpressure: res_valid held until res_ready; start ignored while busy; abort returns to idle next cycle.
// Ports: clk, rst (sync active-low), bus (slave side of systolic_seq_if).
module systolic_seq_ctrl #(
  parameter int N    = 32,
  parameter int M    = 8,
  parameter int KMAX = 256
) (
  input logic          clk,
  input logic          rst,
  systolic_seq_if.slave bus
);
  localparam int KW = $clog2(KMAX + 1);
  localparam int AW = $clog2(KMAX);
  localparam int DW = $clog2(2 * M);

  typedef enum logic [2:0] {IDLE, CLEAR, FEED, DRAIN, DONE} state_t;

  state_t              state;
  logic [KW-1:0]       k_lat;
  logic [KW-1:0]       k_clamp;
  logic [DW-1:0]       dcnt;
  logic [AW-1:0]       addr_q;
  logic                busy_q, rv_q, rd_en_q, clr_q, en_q;
  logic                data_vld;   // buffer data on rd_a/rd_b belongs to a real read
  logic                flush;
  logic [M-1:0][N-1:0] x_out, y_out;

  assign k_clamp = (bus.k_len > KW'(KMAX)) ? KW'(KMAX) : bus.k_len;
  // busy_q is high exactly in CLEAR..DONE, so it doubles as "abort is meaningful".
  assign flush   = !rst || (bus.abort && busy_q);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      k_lat    <= '0;
      dcnt     <= '0;
      addr_q   <= '0;
      busy_q   <= 1'b0;
      rv_q     <= 1'b0;
      rd_en_q  <= 1'b0;
      clr_q    <= 1'b0;
      en_q     <= 1'b0;
      data_vld <= 1'b0;
    end else if (bus.abort && busy_q) begin
      state    <= IDLE;
      dcnt     <= '0;
      addr_q   <= '0;
      busy_q   <= 1'b0;
      rv_q     <= 1'b0;
      rd_en_q  <= 1'b0;
      clr_q    <= 1'b0;
      en_q     <= 1'b0;
      data_vld <= 1'b0;
    end else begin
      data_vld <= rd_en_q;
      case (state)
        IDLE: begin
          if (bus.start) begin
            state  <= CLEAR;
            k_lat  <= k_clamp;
            busy_q <= 1'b1;
            clr_q  <= 1'b1;
          end
        end
        CLEAR: begin
          clr_q <= 1'b0;
          if (k_lat == '0) begin
            state <= DONE;
            rv_q  <= 1'b1;
          end else begin
            state   <= FEED;
            rd_en_q <= 1'b1;
            en_q    <= 1'b1;
            addr_q  <= '0;
          end
        end
        FEED: begin
          if (KW'(addr_q) == k_lat - KW'(1)) begin
            state   <= DRAIN;
            rd_en_q <= 1'b0;
            addr_q  <= '0;
            dcnt    <= '0;
          end else begin
            addr_q <= addr_q + AW'(1);
          end
        end
        DRAIN: begin
          // 2M-1 cycles: enough for the last operand pair to reach PE(M-1,M-1).
          if (dcnt == DW'(2 * M - 2)) begin
            state <= DONE;
            en_q  <= 1'b0;
            rv_q  <= 1'b1;
          end else begin
            dcnt <= dcnt + DW'(1);
          end
        end
        DONE: begin
          if (bus.res_ready) begin
            state  <= IDLE;
            rv_q   <= 1'b0;
            busy_q <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Row/column 0 needs no skew; it passes the returned buffer word straight through.
  assign x_out[0] = data_vld ? bus.rd_a[0] : '0;
  assign y_out[0] = data_vld ? bus.rd_b[0] : '0;

  // Row i / column i are delayed by i cycles so the wavefront meets diagonally.
  for (genvar i = 1; i < M; i++) begin : g_skew
    logic [N-1:0] sx [i];
    logic [N-1:0] sy [i];

    always_ff @(posedge clk) begin
      if (flush) begin
        for (int d = 0; d < i; d++) begin
          sx[d] <= '0;
          sy[d] <= '0;
        end
      end else begin
        sx[0] <= data_vld ? bus.rd_a[i] : '0;
        sy[0] <= data_vld ? bus.rd_b[i] : '0;
        for (int d = 1; d < i; d++) begin
          sx[d] <= sx[d-1];
          sy[d] <= sy[d-1];
        end
      end
    end

    assign x_out[i] = sx[i-1];
    assign y_out[i] = sy[i-1];
  end

  assign bus.busy      = busy_q;
  assign bus.res_valid = rv_q;
  assign bus.rd_en     = rd_en_q;
  assign bus.rd_addr   = addr_q;
  assign bus.arr_clr   = clr_q;
  assign bus.arr_en    = en_q;
  assign bus.arr_x     = x_out;
  assign bus.arr_y     = y_out;
endmodule

// File: tb/tb_systolic_seq_ctrl.sv
// Bench for systolic_seq_ctrl: operand buffer model, behavioural MxM array, per-cycle timing model.
// Model derives every output from start time, K and handshake events with plain arithmetic.
// Directed passes cover identity, constant, K=0, clamp, abort, held result, reset mid-pass, back-to-back.
module tb_systolic_seq_ctrl;
  localparam int N    = 32;
  localparam int M    = 4;
  localparam int KMAX = 16;

  typedef logic [M-1:0][N-1:0] vec_t;

  logic clk;
  logic rst;
  systolic_seq_if #(.N(N), .M(M), .KMAX(KMAX)) bus ();

  systolic_seq_ctrl #(.N(N), .M(M), .KMAX(KMAX)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input logic [63:0] act_v, input logic [63:0] exp_v);
    checks++;
    if (act_v !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act_v, exp_v, cyc);
    end
  endtask

  task automatic chkv(input string nm, input vec_t act_v, input vec_t exp_v);
    checks++;
    if (act_v !== exp_v) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act_v, exp_v, cyc);
    end
  endtask

  // Operand buffer: one-cycle read latency, junk on non-read cycles so gating is visible.
  vec_t amem [KMAX];
  vec_t bmem [KMAX];
  vec_t junk;
  bit   p_vld;
  int   p_addr;
  initial begin
    for (int i = 0; i < M; i++) junk[i] = 32'hDEAD_0000 + i;
    bus.rd_a = junk;
    bus.rd_b = junk;
    forever begin
      @(negedge clk);
      p_vld  = (bus.rd_en === 1'b1);
      p_addr = int'(bus.rd_addr);
      @(posedge clk);
      #1;
      bus.rd_a = p_vld ? amem[p_addr] : junk;
      bus.rd_b = p_vld ? bmem[p_addr] : junk;
    end
  end

  function automatic int el(input vec_t v, input int i);
    int r;
    r = v[i];
    return r;
  endfunction

  // Model state and per-pass measurements.
  bit chk_on = 0;
  bit act = 0;
  int t0 = 0, kk = 0;
  int clr_cnt, rd_cnt, en_cnt, rv_cnt, first_rv, first_x3, first_rd;
  bit rv_checked;
  int acc [M][M], xr [M][M], yr [M][M], acc_snap [M][M];
  int nx [M][M], ny [M][M];
  int rel, dstart, kx, s;
  bit e_busy, e_rd, e_clr, e_en, e_rv;
  vec_t ex, ey;

  always @(negedge clk) begin
    if (chk_on) begin
      rel    = cyc - t0;
      dstart = (kk == 0) ? 2 : kk + 2 * M + 1;
      e_busy = act && rel >= 1;
      e_clr  = act && rel == 1;
      e_rd   = act && rel >= 2 && rel <= kk + 1;
      e_en   = act && kk > 0 && rel >= 2 && rel <= kk + 2 * M;
      e_rv   = act && rel >= dstart;
      for (int i = 0; i < M; i++) begin
        kx = rel - 3 - i;
        ex[i] = (act && kx >= 0 && kx < kk) ? amem[kx][i] : '0;
        ey[i] = (act && kx >= 0 && kx < kk) ? bmem[kx][i] : '0;
      end
      chk("busy", 64'(bus.busy), 64'(e_busy));
      chk("arr_clr", 64'(bus.arr_clr), 64'(e_clr));
      chk("rd_en", 64'(bus.rd_en), 64'(e_rd));
      chk("arr_en", 64'(bus.arr_en), 64'(e_en));
      chk("res_valid", 64'(bus.res_valid), 64'(e_rv));
      if (e_rd) chk("rd_addr", 64'(bus.rd_addr), 64'(rel - 2));
      chkv("arr_x", bus.arr_x, ex);
      chkv("arr_y", bus.arr_y, ey);

      if (bus.arr_clr === 1'b1) clr_cnt++;
      if (bus.rd_en === 1'b1) begin
        rd_cnt++;
        if (first_rd < 0) first_rd = rel;
      end
      if (bus.arr_en === 1'b1) en_cnt++;
      if (bus.res_valid === 1'b1) begin
        rv_cnt++;
        if (first_rv < 0) first_rv = rel;
      end
      if (bus.arr_x[M-1] != '0 && first_x3 < 0) first_x3 = rel;

      // Result check: array accumulators against a plain matrix product.
      if (bus.res_valid === 1'b1 && act && !rv_checked) begin
        rv_checked = 1;
        for (int i = 0; i < M; i++)
          for (int j = 0; j < M; j++) begin
            s = 0;
            for (int k = 0; k < kk; k++) s += el(amem[k], i) * el(bmem[k], j);
            chk($sformatf("C[%0d][%0d]", i, j), 64'(acc[i][j]), 64'(s));
            acc_snap[i][j] = acc[i][j];
          end
      end

      // Behavioural output-stationary array driven by the DUT outputs.
      if (bus.arr_clr === 1'b1) begin
        for (int i = 0; i < M; i++)
          for (int j = 0; j < M; j++) begin
            acc[i][j] = 0; xr[i][j] = 0; yr[i][j] = 0;
          end
      end else if (bus.arr_en === 1'b1) begin
        for (int i = 0; i < M; i++)
          for (int j = 0; j < M; j++) begin
            nx[i][j] = (j == 0) ? el(bus.arr_x, i) : xr[i][j-1];
            ny[i][j] = (i == 0) ? el(bus.arr_y, j) : yr[i-1][j];
            acc[i][j] += nx[i][j] * ny[i][j];
          end
        xr = nx;
        yr = ny;
      end

      // Pass bookkeeping from this cycle's inputs.
      if (rst !== 1'b1) begin
        act = 0;
      end else if (act) begin
        if (bus.abort === 1'b1) act = 0;
        else if (e_rv && bus.res_ready === 1'b1) act = 0;
      end else if (bus.start === 1'b1) begin
        act = 1;
        t0  = cyc;
        kk  = (int'(bus.k_len) > KMAX) ? KMAX : int'(bus.k_len);
        clr_cnt = 0; rd_cnt = 0; en_cnt = 0; rv_cnt = 0;
        first_rv = -1; first_x3 = -1; first_rd = -1;
        rv_checked = 0;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_start(input int k);
    bus.k_len = k[$clog2(KMAX+1)-1:0];
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
  endtask

  task automatic wait_rv(input string nm);
    int n;
    n = 0;
    while (bus.res_valid !== 1'b1 && n < 200) begin
      step();
      n++;
    end
    if (n >= 200) chk({nm, "_rv_timeout"}, 64'(bus.res_valid), 64'(1));
  endtask

  task automatic wait_idle(input string nm);
    int n;
    n = 0;
    while (bus.busy !== 1'b0 && n < 200) begin
      step();
      n++;
    end
    if (n >= 200) chk({nm, "_idle_timeout"}, 64'(bus.busy), 64'(0));
    step();
  endtask

  task automatic clear_mem();
    for (int k = 0; k < KMAX; k++) begin
      amem[k] = '0;
      bmem[k] = '0;
    end
  endtask

  task automatic load_t1();
    clear_mem();
    for (int k = 0; k < 4; k++)
      for (int i = 0; i < M; i++) begin
        amem[k][i] = (i == k) ? 32'd1 : 32'd0;
        bmem[k][i] = 32'(4 * k + i + 1);
      end
  endtask

  task automatic check_acc_b(input string nm);
    for (int i = 0; i < M; i++)
      for (int j = 0; j < M; j++)
        chk($sformatf("%s_C%0d%0d", nm, i, j), 64'(acc_snap[i][j]), 64'(4 * i + j + 1));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    bus.start = 1'b0;
    bus.k_len = '0;
    bus.abort = 1'b0;
    bus.res_ready = 1'b1;
    clear_mem();
    step();
    step();
    chk_on = 1;
    chk("rst_busy", 64'(bus.busy), 64'(0));
    chk("rst_rv", 64'(bus.res_valid), 64'(0));
    chk("rst_rd_en", 64'(bus.rd_en), 64'(0));
    chk("rst_clr", 64'(bus.arr_clr), 64'(0));
    chk("rst_en", 64'(bus.arr_en), 64'(0));
    chk("rst_addr", 64'(bus.rd_addr), 64'(0));
    chkv("rst_x", bus.arr_x, '0);
    rst = 1'b1;
    step();

    // 1: A = I, B = 1..16
    load_t1();
    run_start(4);
    wait_rv("t1");
    wait_idle("t1");
    chk("t1_first_rd", 64'(first_rd), 64'(2));
    chk("t1_rd_cnt", 64'(rd_cnt), 64'(4));
    chk("t1_first_rv", 64'(first_rv), 64'(13));
    chk("t1_rv_cnt", 64'(rv_cnt), 64'(1));
    check_acc_b("t1");

    // 2: all twos
    for (int k = 0; k < 4; k++)
      for (int i = 0; i < M; i++) begin
        amem[k][i] = 32'd2;
        bmem[k][i] = 32'd2;
      end
    run_start(4);
    wait_rv("t2");
    wait_idle("t2");
    chk("t2_first_x3", 64'(first_x3), 64'(6));
    chk("t2_en_cnt", 64'(en_cnt), 64'(11));
    for (int i = 0; i < M; i++)
      for (int j = 0; j < M; j++)
        chk("t2_C", 64'(acc_snap[i][j]), 64'(16));

    // 3a: K = 0
    run_start(0);
    wait_rv("t3a");
    wait_idle("t3a");
    chk("t3a_clr_cnt", 64'(clr_cnt), 64'(1));
    chk("t3a_first_rv", 64'(first_rv), 64'(2));
    chk("t3a_rd_cnt", 64'(rd_cnt), 64'(0));
    chk("t3a_en_cnt", 64'(en_cnt), 64'(0));
    chk("t3a_C00", 64'(acc_snap[0][0]), 64'(0));
    chk("t3a_C33", 64'(acc_snap[3][3]), 64'(0));

    // 3b: k_len above KMAX clamps, signed operands
    for (int k = 0; k < KMAX; k++)
      for (int i = 0; i < M; i++) begin
        amem[k][i] = 32'((i + 1) * (k % 3) - 1);
        bmem[k][i] = 32'(k - i);
      end
    run_start(KMAX + 5);
    wait_rv("t3b");
    wait_idle("t3b");
    chk("t3b_rd_cnt", 64'(rd_cnt), 64'(KMAX));
    chk("t3b_first_rv", 64'(first_rv), 64'(KMAX + 2 * M + 1));

    // 4: abort mid-FEED, then clean pass
    load_t1();
    run_start(4);
    step(); step(); step();
    bus.abort = 1'b1;
    step();
    bus.abort = 1'b0;
    chk("t4_busy", 64'(bus.busy), 64'(0));
    chk("t4_rd_en", 64'(bus.rd_en), 64'(0));
    chk("t4_arr_en", 64'(bus.arr_en), 64'(0));
    repeat (20) step();
    chk("t4_no_rv", 64'(rv_cnt), 64'(0));
    run_start(4);
    wait_rv("t4");
    wait_idle("t4");
    chk("t4_first_rv", 64'(first_rv), 64'(13));
    check_acc_b("t4");

    // 5: start held high while busy, result held with res_ready low
    bus.res_ready = 1'b0;
    bus.k_len = 5'd4;
    bus.start = 1'b1;
    step();
    wait_rv("t5");
    bus.start = 1'b0;
    repeat (5) step();
    chk("t5_rv_held", 64'(bus.res_valid), 64'(1));
    bus.res_ready = 1'b1;
    step();
    chk("t5_rv_drop", 64'(bus.res_valid), 64'(0));
    wait_idle("t5");
    chk("t5_clr_cnt", 64'(clr_cnt), 64'(1));
    // 5 stalled cycles plus the handshake cycle
    chk("t5_rv_cnt", 64'(rv_cnt), 64'(6));
    check_acc_b("t5");

    // 6: reset during DRAIN, then back-to-back passes
    run_start(4);
    repeat (6) step();
    rst = 1'b0;
    step();
    rst = 1'b1;
    chk("t6_busy", 64'(bus.busy), 64'(0));
    chk("t6_arr_en", 64'(bus.arr_en), 64'(0));
    chk("t6_rv", 64'(bus.res_valid), 64'(0));
    chkv("t6_x", bus.arr_x, '0);
    chkv("t6_y", bus.arr_y, '0);
    repeat (20) step();
    chk("t6_no_rv", 64'(rv_cnt), 64'(0));
    for (int p = 0; p < 3; p++) begin
      for (int k = 0; k < KMAX; k++)
        for (int i = 0; i < M; i++) begin
          amem[k][i] = 32'(i + k + p);
          bmem[k][i] = 32'(i * p - k);
        end
      run_start(4 + p);
      wait_rv("t6_b2b");
      step();
    end
    wait_idle("t6_end");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
